// File: rtl/fa_bist_pkg.sv
// Shared definitions for the full-adder built-in self-test controller:
// FSM state encoding and sizing constants.
package fa_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned NVEC  = 8;
  localparam int unsigned VEC_W = 3;
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/fa_bist_ref.sv
// Golden 1-bit full adder used as the expected-value source for the self-test.
module fa_ref (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {1'b0, cin};

endmodule

// File: rtl/fa_bist.sv
// Exhaustive self-test controller for a 1-bit full adder: walks the eight
// {A,B,Cin} vectors, samples S/Cout after a settle time and records errors.
module fa_bist
  import fa_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             cin,
  input  logic             s,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       err_cnt,
  output logic [VEC_W-1:0] fail_vec,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NVEC - 1);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [3:0]         err_cnt_q, err_cnt_d;
  logic [VEC_W-1:0]   fail_vec_q, fail_vec_d;
  logic               first_q, first_d;

  logic               ref_s;
  logic               ref_cout;
  logic               mismatch;

  fa_ref u_ref (
    .a    (vec_q[2]),
    .b    (vec_q[1]),
    .cin  (vec_q[0]),
    .s    (ref_s),
    .cout (ref_cout)
  );

  assign mismatch = ({cout, s} != {ref_cout, ref_s});

  // In RUN the counter runs SETTLE..1; the edge at 1 is the check edge.
  // Counter value 0 is one extra edge after each check, where the next
  // vector is driven, so every vector occupies SETTLE+1 edges.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    fail_vec_d = fail_vec_q;
    first_d    = first_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          vec_d      = '0;
          cnt_d      = SETTLE_C;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_cnt_d  = '0;
          fail_vec_d = '0;
          first_d    = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (cnt_q == CNT_W'(1)) begin
          if (mismatch) begin
            err_cnt_d = err_cnt_q + 4'd1;
            if (!first_q) begin
              fail_vec_d = vec_q;
              first_d    = 1'b1;
            end
          end
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == 4'd0);
          end else begin
            cnt_d = '0;
          end
        end else begin
          vec_d = vec_q + VEC_W'(1);
          cnt_d = SETTLE_C;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      fail_vec_q <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      fail_vec_q <= fail_vec_d;
      first_q    <= first_d;
    end
  end

  assign a         = vec_q[2];
  assign b         = vec_q[1];
  assign cin       = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign fail_vec  = fail_vec_q;
  assign dbg_state = state_q;

endmodule
